// File: rtl/dreimann_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dreimann_turn_ctrl
// Turn sequencer for the Dreimann dice game: commands a roll, waits for the
// dice, classifies the throw and advances the turn.
// Optional macro: DREIMANN_DOUBLES_EN (a double lets the same player re-roll).
// Revision : 1.0 - initial release
// ============================================================================
module dreimann_turn_ctrl #(
  parameter int PLAYERS = 3,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll_req,
  input  logic       roll_done,
  input  logic [2:0] die_a,
  input  logic [2:0] die_b,
  output logic       roll_start,
  output logic       busy,
  output logic [1:0] cur_player,
  output logic [1:0] dreimann,
  output logic       dreimann_valid,
  output logic       event_valid,
  output logic [2:0] event_code
);

  localparam logic [2:0] c_EV_PASS    = 3'd0;
  localparam logic [2:0] c_EV_DREI    = 3'd1;
  localparam logic [2:0] c_EV_SEVEN   = 3'd2;
  localparam logic [2:0] c_EV_DOUBLE  = 3'd3;
  localparam logic [2:0] c_EV_TIMEOUT = 3'd4;
  localparam logic [2:0] c_EV_ERR     = 3'd5;

  localparam logic [1:0] c_LAST_PLAYER = 2'(PLAYERS - 1);
  localparam logic [7:0] c_TIMEOUT     = 8'(TIMEOUT);

`ifdef DREIMANN_DOUBLES_EN
  localparam logic c_DOUBLE_ADVANCE = 1'b0;
`else
  localparam logic c_DOUBLE_ADVANCE = 1'b1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROLL = 2'd1,
    S_WAIT = 2'd2,
    S_EVAL = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic [2:0] r_die_a;
  logic [2:0] r_die_b;
  logic       r_roll_start;
  logic       r_busy;
  logic [1:0] r_cur_player;
  logic [1:0] r_dreimann;
  logic       r_dreimann_valid;
  logic       r_event_valid;
  logic [2:0] r_event_code;

  logic [3:0] w_sum;
  logic       w_die_err;
  logic [2:0] w_code;
  logic       w_advance;
  logic [1:0] w_next_player;

  // Classification of the captured dice, highest priority first.
  always_comb begin
    w_sum     = {1'b0, r_die_a} + {1'b0, r_die_b};
    w_die_err = (r_die_a == 3'd0) || (r_die_a == 3'd7) ||
                (r_die_b == 3'd0) || (r_die_b == 3'd7);
    w_code    = c_EV_PASS;
    if (w_die_err)
      w_code = c_EV_ERR;
    else if ((r_die_a == 3'd3) || (r_die_b == 3'd3))
      w_code = c_EV_DREI;
    else if (w_sum == 4'd7)
      w_code = c_EV_SEVEN;
    else if (r_die_a == r_die_b)
      w_code = c_EV_DOUBLE;
  end

  always_comb begin
    w_advance = 1'b0;
    case (w_code)
      c_EV_PASS, c_EV_SEVEN, c_EV_DREI: w_advance = 1'b1;
      c_EV_DOUBLE:                      w_advance = c_DOUBLE_ADVANCE;
      default:                          w_advance = 1'b0;
    endcase
    w_next_player = (r_cur_player == c_LAST_PLAYER) ? 2'd0 : r_cur_player + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_wait_cnt       <= 8'd0;
      r_die_a          <= 3'd0;
      r_die_b          <= 3'd0;
      r_roll_start     <= 1'b0;
      r_busy           <= 1'b0;
      r_cur_player     <= 2'd0;
      r_dreimann       <= 2'd0;
      r_dreimann_valid <= 1'b0;
      r_event_valid    <= 1'b0;
      r_event_code     <= 3'd0;
    end else begin
      r_roll_start  <= 1'b0;
      r_event_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (roll_req) begin
            r_state      <= S_ROLL;
            r_roll_start <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_ROLL: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= 8'd0;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still beats the timeout.
          if (roll_done) begin
            r_die_a <= die_a;
            r_die_b <= die_b;
            r_state <= S_EVAL;
          end else if ((r_wait_cnt + 8'd1) == c_TIMEOUT) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_wait_cnt    <= 8'd0;
            r_event_valid <= 1'b1;
            r_event_code  <= c_EV_TIMEOUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_EVAL: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_event_valid <= 1'b1;
          r_event_code  <= w_code;
          if (w_code == c_EV_DREI) begin
            r_dreimann       <= r_cur_player;
            r_dreimann_valid <= 1'b1;
          end
          if (w_advance)
            r_cur_player <= w_next_player;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign roll_start     = r_roll_start;
  assign busy           = r_busy;
  assign cur_player     = r_cur_player;
  assign dreimann       = r_dreimann;
  assign dreimann_valid = r_dreimann_valid;
  assign event_valid    = r_event_valid;
  assign event_code     = r_event_code;

endmodule
`default_nettype wire
